// File: rtl/usb_pkt_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkt_pkg
// Shared types and default constants for the FT245-class packet receiver.
//   state_e : framer FSM states
//   err_e   : error cause reported on err_code
//   DEF_*   : default read timing, key symbols, counts and length limit
// ---------------------------------------------------------------------------
package usb_pkt_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_TRAILER = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_TRAILER = 2'd2,
        ERR_CHKSUM  = 2'd3
    } err_e;

    localparam int unsigned DEF_RD_END_CYCLE    = 25;
    localparam int unsigned DEF_RD_STROBE_START = 2;
    localparam int unsigned DEF_RD_STROBE_STOP  = 12;
    localparam int unsigned DEF_RD_SAMPLE       = 9;
    localparam logic [7:0]  DEF_HDR_SYM         = 8'h55;
    localparam int unsigned DEF_HDR_NUM         = 12;
    localparam logic [7:0]  DEF_TRL_SYM         = 8'hAA;
    localparam int unsigned DEF_TRL_NUM         = 8;
    localparam int unsigned DEF_MAX_LEN         = 1024;

endpackage

// File: rtl/ft_rd_engine.sv
// ---------------------------------------------------------------------------
// ft_rd_engine
// Runs the asynchronous FT245 read handshake: synchronises ft_rxf_n, steps a
// read counter 0..RD_END_CYCLE, drives the read strobe, captures the data bus
// and hands the byte on as a one-cycle strobe.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   enable     : a new read may start (downstream slot is empty)
//   ft_rxf_n   : FT data available, active low, asynchronous
//   ft_data    : FT data bus
//   ft_rd_n    : FT read strobe, active low (registered)
//   rd_byte    : captured byte
//   byte_stb   : one-cycle pulse, rd_byte is new
// ---------------------------------------------------------------------------
module ft_rd_engine
    import usb_pkt_pkg::*;
#(
    parameter int unsigned RD_END_CYCLE    = DEF_RD_END_CYCLE,
    parameter int unsigned RD_STROBE_START = DEF_RD_STROBE_START,
    parameter int unsigned RD_STROBE_STOP  = DEF_RD_STROBE_STOP,
    parameter int unsigned RD_SAMPLE       = DEF_RD_SAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ft_rxf_n,
    input  logic [7:0] ft_data,
    output logic       ft_rd_n,
    output logic [7:0] rd_byte,
    output logic       byte_stb
);

    localparam int unsigned CW = $clog2(RD_END_CYCLE + 1);

    logic          rxf_s1_q, rxf_s2_q;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_n_q, rd_n_d;
    logic          stb_q;
    logic [7:0]    data_q;
    logic          start;

    always_comb begin
        start  = !rxf_s2_q && enable;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (!busy_q) begin
            if (start) begin
                busy_d = 1'b1;
                cnt_d  = '0;
            end
        end else if (cnt_q == CW'(RD_END_CYCLE)) begin
            // Wrap straight into the next read so back-to-back bytes take
            // exactly RD_END_CYCLE+1 clocks.
            cnt_d  = '0;
            busy_d = start;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Strobe is registered from the next count so it lines up with the
        // count window without a combinational path to the pin.
        rd_n_d = !(busy_d && (cnt_d >= CW'(RD_STROBE_START))
                          && (cnt_d <  CW'(RD_STROBE_STOP)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxf_s1_q <= 1'b1;
            rxf_s2_q <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            rd_n_q   <= 1'b1;
            stb_q    <= 1'b0;
        end else begin
            rxf_s1_q <= ft_rxf_n;
            rxf_s2_q <= rxf_s1_q;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            rd_n_q   <= rd_n_d;
            stb_q    <= busy_q && (cnt_q == CW'(RD_SAMPLE));
        end
    end

    always_ff @(posedge clk) begin
        if (busy_q && (cnt_q == CW'(RD_SAMPLE))) begin
            data_q <= ft_data;
        end
    end

    assign ft_rd_n  = rd_n_q;
    assign rd_byte  = data_q;
    assign byte_stb = stb_q;

endmodule

// File: rtl/usb_pkt_rx.sv
// ---------------------------------------------------------------------------
// usb_pkt_rx
// FT245 receive engine plus packet framer. A packet is HDR_NUM x HDR_SYM,
// a big-endian 16-bit length, the payload, and TRL_NUM x TRL_SYM.
// Optional feature: define USB_PKT_RX_CHKSUM_EN to require one XOR checksum
// byte between payload and trailer (error 3 on mismatch).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ft_rxf_n, ft_data   : FT data available (active low) and data bus
//   ft_rd_n             : FT read strobe, active low
//   pl_data/valid/last  : payload byte stream, held until pl_ready
//   pl_ready            : downstream accepts the byte
//   pkt_active          : header seen, packet in progress
//   pkt_done, pkt_err   : one-cycle completion / abort pulses
//   err_code            : last error cause, held until the next error
// ---------------------------------------------------------------------------
module usb_pkt_rx
    import usb_pkt_pkg::*;
#(
    parameter int unsigned RD_END_CYCLE    = DEF_RD_END_CYCLE,
    parameter int unsigned RD_STROBE_START = DEF_RD_STROBE_START,
    parameter int unsigned RD_STROBE_STOP  = DEF_RD_STROBE_STOP,
    parameter int unsigned RD_SAMPLE       = DEF_RD_SAMPLE,
    parameter logic [7:0]  HDR_SYM         = DEF_HDR_SYM,
    parameter int unsigned HDR_NUM         = DEF_HDR_NUM,
    parameter logic [7:0]  TRL_SYM         = DEF_TRL_SYM,
    parameter int unsigned TRL_NUM         = DEF_TRL_NUM,
    parameter int unsigned MAX_LEN         = DEF_MAX_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ft_rxf_n,
    input  logic [7:0] ft_data,
    output logic       ft_rd_n,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    output logic       pl_last,
    input  logic       pl_ready,
    output logic       pkt_active,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code
);

`ifdef USB_PKT_RX_CHKSUM_EN
    localparam state_e PL_NEXT = ST_CHK;
`else
    localparam state_e PL_NEXT = ST_TRAILER;
`endif

    logic        byte_stb;
    logic [7:0]  rd_byte;

    state_e      state_q, state_d;
    logic [7:0]  hdr_cnt_q, hdr_cnt_d;
    logic [7:0]  trl_cnt_q, trl_cnt_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] len_rx;
    logic [7:0]  pl_data_q, pl_data_d;
    logic        pl_valid_q, pl_valid_d;
    logic        pl_last_q, pl_last_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    err_e        err_code_q, err_code_d;
`ifdef USB_PKT_RX_CHKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    // Reads are only allowed while the output slot is empty, so a stalled
    // consumer can never be overrun.
    ft_rd_engine #(
        .RD_END_CYCLE    (RD_END_CYCLE),
        .RD_STROBE_START (RD_STROBE_START),
        .RD_STROBE_STOP  (RD_STROBE_STOP),
        .RD_SAMPLE       (RD_SAMPLE)
    ) u_rd (
        .clk      (clk),
        .rst      (rst),
        .enable   (!pl_valid_q),
        .ft_rxf_n (ft_rxf_n),
        .ft_data  (ft_data),
        .ft_rd_n  (ft_rd_n),
        .rd_byte  (rd_byte),
        .byte_stb (byte_stb)
    );

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        trl_cnt_d  = trl_cnt_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        pl_data_d  = pl_data_q;
        pl_valid_d = pl_valid_q;
        pl_last_d  = pl_last_q;
        active_d   = active_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        len_rx     = {len_hi_q, rd_byte};
`ifdef USB_PKT_RX_CHKSUM_EN
        chk_d      = chk_q;
`endif

        if (pl_valid_q && pl_ready) begin
            pl_valid_d = 1'b0;
            pl_last_d  = 1'b0;
        end

        if (byte_stb) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (rd_byte == HDR_SYM) begin
                        if (hdr_cnt_q + 8'd1 == 8'(HDR_NUM)) begin
                            hdr_cnt_d = '0;
                            active_d  = 1'b1;
                            state_d   = ST_LEN_HI;
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + 8'd1;
                        end
                    end else begin
                        hdr_cnt_d = '0;
                    end
                end
                ST_LEN_HI: begin
                    len_hi_d = rd_byte;
                    state_d  = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d      = len_rx;
                    byte_cnt_d = '0;
                    trl_cnt_d  = '0;
`ifdef USB_PKT_RX_CHKSUM_EN
                    chk_d      = '0;
`endif
                    if (len_rx > 16'(MAX_LEN)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                        active_d   = 1'b0;
                        state_d    = ST_HUNT;
                    end else if (len_rx == 16'd0) begin
                        state_d = PL_NEXT;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    pl_data_d  = rd_byte;
                    pl_valid_d = 1'b1;
                    byte_cnt_d = byte_cnt_q + 16'd1;
`ifdef USB_PKT_RX_CHKSUM_EN
                    chk_d      = chk_q ^ rd_byte;
`endif
                    pl_last_d  = (byte_cnt_d == len_q);
                    if (byte_cnt_d == len_q) begin
                        state_d = PL_NEXT;
                    end
                end
`ifdef USB_PKT_RX_CHKSUM_EN
                ST_CHK: begin
                    if (rd_byte == chk_q) begin
                        state_d = ST_TRAILER;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHKSUM;
                        active_d   = 1'b0;
                        state_d    = ST_HUNT;
                    end
                end
`endif
                ST_TRAILER: begin
                    if (rd_byte == TRL_SYM) begin
                        if (trl_cnt_q + 8'd1 == 8'(TRL_NUM)) begin
                            trl_cnt_d = '0;
                            done_d    = 1'b1;
                            active_d  = 1'b0;
                            state_d   = ST_HUNT;
                        end else begin
                            trl_cnt_d = trl_cnt_q + 8'd1;
                        end
                    end else begin
                        trl_cnt_d  = '0;
                        err_d      = 1'b1;
                        err_code_d = ERR_TRAILER;
                        active_d   = 1'b0;
                        state_d    = ST_HUNT;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            hdr_cnt_q  <= '0;
            trl_cnt_q  <= '0;
            len_hi_q   <= '0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            pl_data_q  <= '0;
            pl_valid_q <= 1'b0;
            pl_last_q  <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
`ifdef USB_PKT_RX_CHKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            trl_cnt_q  <= trl_cnt_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            pl_data_q  <= pl_data_d;
            pl_valid_q <= pl_valid_d;
            pl_last_q  <= pl_last_d;
            active_q   <= active_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
`ifdef USB_PKT_RX_CHKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign pl_data    = pl_data_q;
    assign pl_valid   = pl_valid_q;
    assign pl_last    = pl_last_q;
    assign pkt_active = active_q;
    assign pkt_done   = done_q;
    assign pkt_err    = err_q;
    assign err_code   = err_code_q;

endmodule
